div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL expose `clk  input  1`, the single rising-edge clock for all state.
REQ-002 The block SHALL expose `reset  input  1`, a synchronous active-low reset: when reset==0 at a rising edge of clk, the block is reset.
REQ-003 The block SHALL expose `A  input  32`, the dividend, a signed two's-complement value.
REQ-004 The block SHALL expose `B  input  32`, the divisor, a signed two's-complement value.
REQ-005 The block SHALL expose `div_control  input  1`, the start request, sampled only in IDLE.
REQ-006 The block SHALL expose `hi  output  32`, the remainder.
REQ-007 The block SHALL expose `lo  output  32`, the quotient.
REQ-008 The block SHALL expose `div_end  output  1`, a one-cycle completion pulse.
REQ-009 The block SHALL expose `div_zero  output  1`, the divide-by-zero flag, valid while div_end==1.

Function
REQ-010 The block SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-011 In IDLE, when div_control==1 at an edge, the block SHALL latch A and B in that same edge.
REQ-012 If the latched B!=0, the block SHALL go to CALC with the cycle counter set to 0.
REQ-013 If the latched B==0, the block SHALL go directly to DONE.
REQ-014 CALC SHALL perform one restoring shift-subtract step per cycle on |A| and |B| (64-bit remainder:quotient working register).
REQ-015 CALC SHALL last exactly 32 cycles (counter 0..31) and then go to FIX.
REQ-016 FIX SHALL apply the signs in one cycle, then go to DONE:
- quotient negated when sign(A)!=sign(B);
- remainder negated when A<0.
REQ-017 DONE SHALL last one cycle, then return to IDLE.
REQ-018 div_end SHALL be 1 only in DONE.
REQ-019 hi and lo SHALL update on the edge entering DONE and SHALL hold until the next entry into DONE or reset.
REQ-020 Latency SHALL be 34 edges from the sampling edge to DONE for B!=0, and 1 edge for B==0.
REQ-021 Quotient SHALL truncate toward zero, and the remainder SHALL carry the sign of the dividend.
REQ-022 The relation A == lo*B + hi (mod 2^32) SHALL hold for every B!=0.
REQ-023 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag raised (wrap).
REQ-024 For B==0, the block SHALL set div_zero=1 and leave hi and lo unchanged.
REQ-025 div_zero SHALL be 0 on every completion with B!=0, and 0 outside DONE.
REQ-026 div_control asserted in CALC, FIX or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 Changes on A or B after the sampling edge SHALL NOT affect the result.
REQ-028 div_control held high continuously SHALL start a new operation at the first IDLE edge after DONE.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE and the counter and working register SHALL be cleared.
REQ-030 On reset, hi, lo, div_end and div_zero SHALL all be 0.
REQ-031 Reset SHALL have priority over div_control.
REQ-032 Reset during CALC or FIX SHALL abort the operation without producing a div_end pulse.
REQ-033 Reset SHALL act only at a clock edge; an asynchronous reset assertion SHALL have no effect.

Structure
REQ-034 The shared CPU package SHALL hold the data width (32), the FSM state encodings and the iteration count (32), shared with the multiplier control.
REQ-035 One combinational sub-module `div_step` SHALL perform a single shift/compare/subtract iteration, instantiated once in CALC.
REQ-036 Negation and absolute-value logic SHALL stay inside div.

Verification
REQ-037 Bench: A=100, B=7 -> lo=14, hi=2, div_zero=0, div_end high exactly 34 edges after the start edge.
REQ-038 Bench: A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 Bench: prior result lo=14 and hi=2, then A=5, B=0 -> div_end after 1 edge, div_zero=1, lo=14, hi=2.
REQ-040 Bench: A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-041 Bench: start A=100, B=7, then at CALC cycle 10 pulse div_control with A=9, B=3 -> ignored; result remains lo=14, hi=2.
REQ-042 Bench: start, then reset=0 at CALC cycle 10 -> no div_end; all outputs 0 the next cycle; a new start then completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared CPU arithmetic package: data width, iteration count and the
// sequencer state encoding used by the divider (and the multiplier control).
package div_pkg;

  localparam int DATA_W = 32;
  localparam int ITER_N = 32;
  localparam int CNT_W  = $clog2(ITER_N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] shl;
  logic [DATA_W:0] diff;

  // Compare/subtract on the shifted remainder; keep it when the divisor does not fit.
  always_comb begin
    shl  = {rem_i, quot_i[DATA_W-1]};
    diff = shl - {1'b0, dvs_i};
    if (shl >= {1'b0, dvs_i}) begin
      rem_o  = diff[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o  = shl[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// Sequential signed 32-bit divider: 32 restoring steps on magnitudes, then a
// sign-fix cycle. Results land in hi (remainder) / lo (quotient) on DONE entry.
module div
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              div_control,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_end,
  output logic              div_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] wrk_q;     // {remainder, quotient}
  logic [DATA_W-1:0]   dvs_q;     // |B|
  logic                sa_q, sb_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                dz_q;

  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W-1:0]   st_rem, st_quot;
  logic                start, b_zero;

  function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Magnitudes of the incoming operands; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_abs  = A[DATA_W-1] ? neg(A) : A;
    b_abs  = B[DATA_W-1] ? neg(B) : B;
    b_zero = (B == '0);
    start  = (state_q == ST_IDLE) && div_control;
  end

  div_step u_step (
    .rem_i  (wrk_q[2*DATA_W-1:DATA_W]),
    .quot_i (wrk_q[DATA_W-1:0]),
    .dvs_i  (dvs_q),
    .rem_o  (st_rem),
    .quot_o (st_quot)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero divisor skips straight to DONE; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (div_control) state_d = b_zero ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      wrk_q <= '0;
      dvs_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      dz_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sa_q  <= A[DATA_W-1];
            sb_q  <= B[DATA_W-1];
            dvs_q <= b_abs;
            wrk_q <= {{DATA_W{1'b0}}, a_abs};
            cnt_q <= '0;
            dz_q  <= b_zero;
          end
        end
        ST_CALC: begin
          wrk_q <= {st_rem, st_quot};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          lo_q <= (sa_q ^ sb_q) ? neg(wrk_q[DATA_W-1:0]) : wrk_q[DATA_W-1:0];
          hi_q <= sa_q ? neg(wrk_q[2*DATA_W-1:DATA_W]) : wrk_q[2*DATA_W-1:DATA_W];
        end
        default: ;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_end  = (state_q == ST_DONE);
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized
// operations compared against a 64-bit arithmetic reference.
module tb_div;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        div_control;
  logic [31:0] hi, lo;
  logic        div_end, div_zero;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  div dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .B           (B),
    .div_control (div_control),
    .hi          (hi),
    .lo          (lo),
    .div_end     (div_end),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit signed division truncates toward zero; remainder follows
  // the dividend. Low 32 bits give the wrapped results.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] elo, output logic [31:0] ehi, output logic edz);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      elo = exp_lo; ehi = exp_hi; edz = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      elo = q[31:0]; ehi = r[31:0]; edz = 1'b0;
    end
  endtask

  // Start one operation from IDLE (called at posedge+1). If inj>0, a second
  // request (9/3) is pulsed that many edges after the start edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int inj);
    int n;
    logic [31:0] elo, ehi;
    logic edz;
    model(a, b, elo, ehi, edz);
    A = a; B = b; div_control = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (div_end !== 1'b1 && n < 60) begin
      div_control = (n == inj);
      A = (n == inj) ? 32'd9 : $urandom;
      B = (n == inj) ? 32'd3 : $urandom;
      @(posedge clk); #1;
      n++;
    end
    div_control = 1'b0;
    chk({tag, "_lat"}, n, (b == 0) ? 1 : 34);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_dz"}, div_zero, edz);
    exp_lo = elo; exp_hi = ehi;
    @(posedge clk); #1;
    chk({tag, "_endclr"}, div_end, 1'b0);
    chk({tag, "_dzclr"}, div_zero, 1'b0);
  endtask

  initial begin
    int n, m, seen;
    logic [31:0] ra, rb, elo, ehi;
    logic edz;
    reset = 1'b0; div_control = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_end", div_end, 0);
    chk("rst_dz", div_zero, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("d100_7", 32'd100, 32'd7, 0);
    run_op("dm7_2", 32'hFFFFFFF9, 32'd2, 0);
    chk("dm7_2_lo_lit", lo, 32'hFFFFFFFD);
    run_op("d100_7b", 32'd100, 32'd7, 0);
    run_op("d5_0", 32'd5, 32'd0, 0);
    chk("d5_0_lo_lit", lo, 32'd14);
    chk("d5_0_hi_lit", hi, 32'd2);
    run_op("wrap", 32'h80000000, 32'hFFFFFFFF, 0);
    chk("wrap_lo_lit", lo, 32'h80000000);
    run_op("ign", 32'd100, 32'd7, 10);
    chk("ign_lo_lit", lo, 32'd14);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_end) seen++;
    end
    chk("ign_noqueue", seen, 0);

    // Asynchronous reset glitch between edges must not disturb results.
    reset = 1'b0; #2; reset = 1'b1;
    @(posedge clk); #1;
    chk("glitch_lo", lo, exp_lo);
    chk("glitch_hi", hi, exp_hi);

    // Reset in the middle of CALC aborts without a completion pulse.
    A = 32'd100; B = 32'd7; div_control = 1'b1;
    @(posedge clk); #1;
    div_control = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (div_end) seen++;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_end", div_end, 0);
    chk("abort_dz", div_zero, 0);
    exp_hi = '0; exp_lo = '0;
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (div_end) seen++;
    end
    chk("abort_noend", seen, 0);
    run_op("after_abort", 32'd100, 32'd7, 0);

    // Request held high: the next op starts on the first IDLE edge after DONE.
    model(32'd21, 32'hFFFFFFFC, elo, ehi, edz);
    A = 32'd21; B = 32'hFFFFFFFC; div_control = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (div_end !== 1'b1 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("held_lat", n, 34);
    chk("held_lo", lo, elo);
    chk("held_hi", hi, ehi);
    m = 0;
    do begin
      @(posedge clk); #1; m++;
    end while (div_end !== 1'b1 && m < 80);
    chk("held_gap", m, 35);
    div_control = 1'b0;
    exp_lo = elo; exp_hi = ehi;
    repeat (3) @(posedge clk);
    #1;
    chk("held_stop", div_end, 0);

    // Randomized operations, mixing full-range, small and zero divisors.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: ra = $urandom;
        1: ra = 32'($signed($urandom_range(200)) - 100);
        2: ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2, 3: rb = 32'($signed($urandom_range(40)) - 20);
        default: rb = $urandom;
      endcase
      run_op("rnd", ra, rb, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
